fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the 4096 x 19-bit instruction memory. It owns the program counter, drives the memory address, and resolves JMP, JSB, RET and conditional branch locally, with a hardware return-address stack. Only non-control-flow instructions reach the decoder, through a one-entry valid/ready output register.

## Interface
- ADDR_W, 12, PC / memory address width
- INSTR_W, 19, instruction width
- STACK_DEPTH, 8, return-stack entries (power of two)
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  ADDR_W  instruction memory address; always equals pc
- imem_instr  in  INSTR_W  memory read data for imem_addr, valid same cycle (combinational read)
- flag_z  in  1  zero flag from execute
- flag_c  in  1  carry flag from execute
- exec_idle  in  1  execute has retired everything issued; flags are final
- instr_out  out  INSTR_W  instruction to decoder
- instr_valid  out  1  instr_out holds an unconsumed instruction
- instr_ready  in  1  decoder accepts instr_out this cycle
- fault  out  1  sticky return-stack overflow/underflow

## Operation
- States:
  - WAIT: one cycle after reset release, so memory contents can settle.
  - FETCH: normal operation.
  - FAULT: terminal; exits only via rst.
- Predecode of imem_instr, bit 18 = MSB:
  - JMP: [18:14]=11100, [13:12]=11; target [11:0].
  - JSB: [18:14]=11101, [13:12]=11; target [11:0].
  - RET: [18:13]=111100.
  - BR: [18:16]=101; cond [15:14]; offset [7:0], unsigned.
  - Anything else is an ordinary instruction.
- slot_free = !instr_valid || instr_ready. The sequencer advances only in FETCH with slot_free.
- Ordinary instruction: instr_out <= imem_instr, instr_valid <= 1, pc <= pc+1.
- JMP: pc <= target; nothing emitted; instr_valid clears if the slot was consumed.
- JSB: push pc+1, then pc <= target. Push while the stack is full: enter FAULT, pc unchanged.
- RET: pc <= popped top. Pop while the stack is empty: enter FAULT, pc unchanged.
- BR conditions: 00 taken if Z, 01 if !Z, 10 if C, 11 if !C.
  - BR evaluates only when exec_idle=1 and instr_valid=0; otherwise it holds, with pc unchanged.
  - Taken: pc <= pc+1+offset. Not taken: pc <= pc+1.
- All PC arithmetic is mod 2^ADDR_W: 4095+1 = 0, and branch targets wrap.
- In FAULT: instr_valid drops once the current slot is consumed, and no further fetches occur. fault=1.

## Timing
- Reset values:
  - pc = RESET_PC, imem_addr = RESET_PC.
  - instr_out = 0, instr_valid = 0, fault = 0.
  - stack pointer = 0 (stack contents undefined); state = WAIT.
- rst asserted mid-operation: all of the above take effect immediately; the pending slot and stack are discarded.
- Ordinary instructions: one per cycle at full throughput when instr_ready=1. instr_out is registered, so latency is 1 cycle from pc to instr_valid.
- JMP, JSB, RET, taken or untaken BR: one cycle each, emitting no instruction; this is the only redirect bubble.
- Back-pressure: while instr_valid=1 and instr_ready=0, instr_out, pc and imem_addr are all stable.
- Same-cycle consume and load is allowed: the slot is refilled with no gap.

## Configuration
- FETCH_SEQ_CALL_STACK_EN defined: JSB and RET behave as described above, with a STACK_DEPTH-entry stack and fault detection.
- FETCH_SEQ_CALL_STACK_EN undefined:
  - No stack is instantiated.
  - JSB and RET are treated as ordinary instructions and forwarded to the decoder.
  - fault is tied to 0.
  - JMP and BR are unchanged.

## Test plan
- Straight-line code: reset, RESET_PC=7, ordinary instructions at 7..9, instr_ready=1 -> instr_valid from the second cycle after WAIT, instr_out sequence mem[7], mem[8], mem[9]; pc sequence 7, 8, 9, 10.
- JMP to 20 at address 14 -> mem[20] is emitted next, with exactly one bubble cycle; nothing from 15..19 is emitted.
- JSB to 32 at address 21, then RET at 34 -> pc sequence 21, 32, 33, 34, 22; stack pointer returns to 0.
- BR cond 00, offset 8 at address 30, with flag_z=1 and exec_idle held low for 3 cycles -> pc holds at 30 for 3 cycles, then goes to 39. Repeat with flag_z=0 -> pc goes to 31.
- Nine nested JSBs with STACK_DEPTH=8 -> fault=1 on the ninth and pc stays at its address. A RET after reset -> fault=1. Asserting rst clears fault.
- instr_ready=0 for 5 cycles with instr_valid=1 -> instr_out and imem_addr stay constant. Also: pc wraps 4095 -> 0, and a BR at 4090 with offset 10 lands at 5.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, resolves JMP/JSB/RET/BR locally and forwards
// ordinary instructions through a one-entry valid/ready register. Optional return stack: FETCH_SEQ_CALL_STACK_EN.
module fetch_sequencer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned INSTR_W     = 19,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               flag_z,
    input  logic               flag_c,
    input  logic               exec_idle,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fault
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    logic              slot_free;
    logic              is_jmp;
    logic              is_jsb;
    logic              is_ret;
    logic              is_br;
    logic              br_taken;
    logic              br_ready;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] br_target;

    assign imem_addr = pc;
    assign slot_free = !instr_valid || instr_ready;

    // Predecode of the word currently presented by memory
    assign is_jmp = (imem_instr[18:12] == 7'b1110011);
    assign is_jsb = (imem_instr[18:12] == 7'b1110111);
    assign is_ret = (imem_instr[18:13] == 6'b111100);
    assign is_br  = (imem_instr[18:16] == 3'b101);

    assign pc_inc     = pc + ADDR_W'(1);
    assign jmp_target = ADDR_W'(imem_instr[11:0]);

    always_comb begin
        br_taken = 1'b0;
        case (imem_instr[15:14])
            2'b00:   br_taken = flag_z;
            2'b01:   br_taken = !flag_z;
            2'b10:   br_taken = flag_c;
            default: br_taken = !flag_c;
        endcase
    end

    // Flags are only trusted once execute has drained and nothing is queued for it
    assign br_ready  = exec_idle && !instr_valid;
    assign br_target = pc_inc + (br_taken ? ADDR_W'(imem_instr[7:0]) : ADDR_W'(0));

`ifdef FETCH_SEQ_CALL_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic              stack_full;
    logic              stack_empty;
    logic              do_push;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == SP_W'(0));
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - SP_W'(1));
    assign do_push     = (state == S_FETCH) && slot_free && is_jsb && !stack_full;

    // Stack contents need no reset; only the pointer is architectural
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT;
            pc          <= ADDR_W'(RESET_PC);
            instr_out   <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_SEQ_CALL_STACK_EN
            fault       <= 1'b0;
            sp          <= '0;
`endif
        end else begin
            // A consumed slot empties unless refilled below in the same cycle
            if (instr_ready) begin
                instr_valid <= 1'b0;
            end
            case (state)
                S_WAIT: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (slot_free) begin
                        if (is_jmp) begin
                            pc <= jmp_target;
`ifdef FETCH_SEQ_CALL_STACK_EN
                        end else if (is_jsb) begin
                            if (stack_full) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                sp <= sp + SP_W'(1);
                                pc <= jmp_target;
                            end
                        end else if (is_ret) begin
                            if (stack_empty) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                sp <= sp - SP_W'(1);
                                pc <= stack_mem[top_idx];
                            end
`endif
                        end else if (is_br) begin
                            if (br_ready) begin
                                pc <= br_target;
                            end
                        end else begin
                            instr_out   <= imem_instr;
                            instr_valid <= 1'b1;
                            pc          <= pc_inc;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

`ifndef FETCH_SEQ_CALL_STACK_EN
    logic unused_ok;
    assign unused_ok = is_jsb ^ is_ret;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program phases plus randomized handshake and
// flags, checked every cycle against a queue-based architectural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int unsigned RST_PC = 7;
    localparam int K_ORD = 0;
    localparam int K_JMP = 1;
    localparam int K_JSB = 2;
    localparam int K_RET = 3;
    localparam int K_BR  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] imem_addr;
    logic [18:0] imem_instr;
    logic        flag_z = 1'b0;
    logic        flag_c = 1'b0;
    logic        exec_idle = 1'b0;
    logic [18:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        fault;

    logic [18:0] mem [4096];

    int vectors = 0;
    int miscompares = 0;

    // Architectural model state
    logic [11:0] m_pc;
    logic        m_valid;
    logic [18:0] m_out;
    logic        m_fault;
    logic        m_wait;
    logic [11:0] ret_q [$];

    assign imem_instr = mem[imem_addr];

    fetch_sequencer #(
        .ADDR_W     (12),
        .INSTR_W    (19),
        .STACK_DEPTH(8),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .exec_idle  (exec_idle),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] w_jmp(input int t);
        return {7'b1110011, 12'(t)};
    endfunction
    function automatic logic [18:0] w_jsb(input int t);
        return {7'b1110111, 12'(t)};
    endfunction
    function automatic logic [18:0] w_ret();
        return {6'b111100, 13'd0};
    endfunction
    function automatic logic [18:0] w_br(input int c, input int off);
        return {3'b101, 2'(c), 6'd0, 8'(off)};
    endfunction
    function automatic logic [18:0] w_ord();
        return {1'b0, 18'($urandom)};
    endfunction

    function automatic int kind_of(input logic [18:0] i);
        if (i[18:12] == 7'b1110011) return K_JMP;
`ifdef FETCH_SEQ_CALL_STACK_EN
        if (i[18:12] == 7'b1110111) return K_JSB;
        if (i[18:13] == 6'b111100)  return K_RET;
`endif
        if (i[18:16] == 3'b101)     return K_BR;
        return K_ORD;
    endfunction

    function automatic logic [11:0] wrap(input int v);
        return 12'(v % 4096);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    32'(imem_addr),   32'(m_pc));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(m_valid));
        chk({tag, ".instr"}, 32'(instr_out),   32'(m_out));
        chk({tag, ".fault"}, 32'(fault),       32'(m_fault));
    endtask

    // One clock of the fetch rules, evaluated with the inputs currently driven
    task automatic model_step();
        logic [18:0] ins;
        logic        was_valid;
        logic        taken;
        int          off;
        ins       = mem[m_pc];
        was_valid = m_valid;
        if (m_wait) begin
            m_wait = 1'b0;
        end else if (m_fault) begin
            if (instr_ready) m_valid = 1'b0;
        end else if (!was_valid || instr_ready) begin
            m_valid = 1'b0;
            case (kind_of(ins))
                K_JMP: m_pc = ins[11:0];
                K_JSB: begin
                    if (ret_q.size() == 8) m_fault = 1'b1;
                    else begin
                        ret_q.push_back(wrap(int'(m_pc) + 1));
                        m_pc = ins[11:0];
                    end
                end
                K_RET: begin
                    if (ret_q.size() == 0) m_fault = 1'b1;
                    else m_pc = ret_q.pop_back();
                end
                K_BR: begin
                    if (exec_idle && !was_valid) begin
                        case (ins[15:14])
                            2'b00:   taken = flag_z;
                            2'b01:   taken = !flag_z;
                            2'b10:   taken = flag_c;
                            default: taken = !flag_c;
                        endcase
                        off  = taken ? int'(ins[7:0]) : 0;
                        m_pc = wrap(int'(m_pc) + 1 + off);
                    end
                end
                default: begin
                    m_valid = 1'b1;
                    m_out   = ins;
                    m_pc    = wrap(int'(m_pc) + 1);
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk_all("cyc");
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_pc    = 12'(RST_PC);
        m_valid = 1'b0;
        m_out   = '0;
        m_fault = 1'b0;
        m_wait  = 1'b1;
        ret_q.delete();
        #1;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_ordinary();
        for (int a = 0; a < 4096; a++) mem[a] = w_ord();
    endtask

    task automatic rand_inputs(input int ready_pct, input int z_pct);
        instr_ready = ($urandom_range(99) < 32'(ready_pct));
        flag_z      = ($urandom_range(99) < 32'(z_pct));
        flag_c      = 1'($urandom);
        exec_idle   = 1'($urandom);
    endtask

    task automatic br_phase(input logic z, input int expect_pc);
        fill_ordinary();
        mem[7]  = w_jmp(30);
        mem[30] = w_br(0, 8);
        instr_ready = 1'b1;
        exec_idle   = 1'b0;
        flag_z      = z;
        do_reset();
        for (int i = 0; i < 20 && imem_addr != 12'd30; i++) tick();
        chk("br_reach", 32'(imem_addr), 32'd30);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("br_hold", 32'(imem_addr), 32'd30);
        end
        exec_idle = 1'b1;
        tick();
        chk("br_dest", 32'(imem_addr), 32'(expect_pc));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Phase 1: mixed program under randomized handshake and flags
        fill_ordinary();
        mem[14]   = w_jmp(20);
        mem[21]   = w_jsb(32);
        mem[30]   = w_br(0, 8);
        mem[34]   = w_ret();
        mem[39]   = w_jmp(4093);
        mem[4]    = w_jmp(4090);
        mem[4090] = w_br(1, 10);
        mem[4091] = w_jmp(7);
        mem[5]    = w_jmp(7);
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("straight_pc", 32'(imem_addr), 32'd10);
        chk("straight_instr", 32'(instr_out), 32'(mem[9]));
        for (int i = 0; i < 400; i++) begin
            rand_inputs(75, 85);
            tick();
        end

        // Phase 2: branch held off by exec_idle, then taken / not taken
        br_phase(1'b1, 39);
        br_phase(1'b0, 31);

        // Phase 3: return-stack overflow, reset recovery, underflow
        fill_ordinary();
        mem[7] = w_jsb(7);
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
`ifdef FETCH_SEQ_CALL_STACK_EN
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_pc", 32'(imem_addr), 32'd7);
`else
        chk("jsb_fwd_pc", 32'(imem_addr), 32'd18);
`endif
        do_reset();
        chk("rst_clears_fault", 32'(fault), 32'd0);
        mem[7] = w_ret();
        for (int i = 0; i < 2; i++) tick();
`ifdef FETCH_SEQ_CALL_STACK_EN
        chk("unf_fault", 32'(fault), 32'd1);
        chk("unf_pc", 32'(imem_addr), 32'd7);
`else
        chk("ret_fwd", 32'(instr_out), 32'(w_ret()));
`endif

        // Phase 4: back-pressure holds slot and address
        fill_ordinary();
        instr_ready = 1'b1;
        do_reset();
        tick();
        instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_instr", 32'(instr_out), 32'(mem[7]));
            chk("bp_addr", 32'(imem_addr), 32'd8);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Phase 5: PC wrap 4095 -> 0
        mem[7] = w_jmp(4094);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("wrap_pc", 32'(imem_addr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
